// File: rtl/cpu_mulx_seq.sv
// Sequential 32x32 multiplier: four 16x16 partial products and a signed high-word correction.
// Fixed 7-cycle latency from accept to done; flush kills the operation, start ignored while busy.
module cpu_mulx_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [2:0] {IDLE, PP0, PP1, PP2, PP3, ACC, CORR, DONE} state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic [31:0] a_q, b_q;
    logic [1:0]  op_q;
    logic [63:0] acc;
    logic [63:0] addend;
    logic [31:0] prod;
    logic [15:0] mul_a, mul_b;
    logic [31:0] hi_corr;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: if (start && !flush) begin
                accept    = 1'b1;
                state_nxt = PP0;
            end
            PP0:  state_nxt = PP1;
            PP1:  state_nxt = PP2;
            PP2:  state_nxt = PP3;
            PP3:  state_nxt = ACC;
            ACC:  state_nxt = CORR;
            CORR: state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush && state != IDLE)
            state_nxt = IDLE;
    end

    // Operand select for the single shared multiplier; its product lands one state later.
    always_comb begin
        mul_a = 16'h0;
        mul_b = 16'h0;
        case (state)
            PP0: begin mul_a = a_q[15:0];  mul_b = b_q[15:0];  end
            PP1: begin mul_a = a_q[31:16]; mul_b = b_q[15:0];  end
            PP2: begin mul_a = a_q[15:0];  mul_b = b_q[31:16]; end
            PP3: begin mul_a = a_q[31:16]; mul_b = b_q[31:16]; end
            default: ;
        endcase
    end

    always_comb begin
        addend = 64'h0;
        case (state)
            PP1:      addend = {32'h0, prod};
            PP2, PP3: addend = {16'h0, prod, 16'h0};
            ACC:      addend = {prod, 32'h0};
            default:  ;
        endcase
    end

    // Signed high word from the unsigned product: subtract the other operand per negative signed input.
    always_comb begin
        hi_corr = acc[63:32];
        if (op_q[1] && a_q[31])
            hi_corr = hi_corr - b_q;
        if (op_q == 2'b11 && b_q[31])
            hi_corr = hi_corr - a_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            a_q    <= 32'h0;
            b_q    <= 32'h0;
            op_q   <= 2'b00;
            acc    <= 64'h0;
            prod   <= 32'h0;
            result <= 32'h0;
        end else begin
            state <= state_nxt;
            prod  <= 32'(mul_a) * 32'(mul_b);
            if (accept) begin
                a_q  <= src1;
                b_q  <= src2;
                op_q <= op;
                acc  <= 64'h0;
            end else begin
                acc <= acc + addend;
            end
            if (state == CORR && !flush)
                result <= (op_q == 2'b00) ? acc[31:0] : hi_corr;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
